// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the MMIO bridge: address map, FSM states, target decode.
// No ports; imported by the interface, the RAM and the top.
package mmio_bridge_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam addr_t GPIO_BASE   = 32'h1000_0000;
    localparam addr_t DBG_BASE    = 32'h2000_0000;
    localparam addr_t PC_ADDR     = 32'h2000_0080;
    localparam addr_t CYC_LO_ADDR = 32'h2000_0084;
    localparam addr_t CYC_HI_ADDR = 32'h2000_0088;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    typedef enum logic [2:0] {
        TgtRam, TgtGpio, TgtDbg, TgtPc, TgtCycLo, TgtCycHi, TgtErr
    } tgt_e;

    // Any read-only target receiving a nonzero strobe decodes as TgtErr, so an errored
    // access never reaches a target with side effects.
    function automatic tgt_e decode(addr_t a, logic [3:0] wstrb,
                                    int unsigned mem_words, int unsigned num_gpio);
        logic wr;
        wr = |wstrb;
        if (a[1:0] != 2'b00) return TgtErr;
        if (a < 32'(4 * mem_words)) return TgtRam;
        if (a >= GPIO_BASE && (a - GPIO_BASE) < 32'(4 * num_gpio)) return TgtGpio;
        if (a >= DBG_BASE && a < DBG_BASE + 32'h80) return wr ? TgtErr : TgtDbg;
        if (a == PC_ADDR) return wr ? TgtErr : TgtPc;
        if (a == CYC_LO_ADDR) return wr ? TgtErr : TgtCycLo;
        if (a == CYC_HI_ADDR) return wr ? TgtErr : TgtCycHi;
        return TgtErr;
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Request/response handshake bundle between the core load/store port and the bridge.
// master: core side (drives req_*, resp_ready). slave: bridge side (drives req_ready, resp_*).
interface mmio_bridge_if;
    import mmio_bridge_pkg::*;

    logic       req_valid;
    logic       req_ready;
    addr_t      req_addr;
    data_t      req_wdata;
    logic [3:0] req_wstrb;
    logic       resp_valid;
    logic       resp_ready;
    data_t      resp_rdata;
    logic       resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mmio_bridge_bytelane_ram.sv
// Word-addressed RAM built from four 8-bit lanes with per-lane write enables and a
// registered read port (read-before-write). Contents are not reset.
// Ports: clk, i_en (access enable), i_we (lane write enables), i_addr (word index),
//        i_wdata (write word), o_rdata (registered read word).
module mmio_bridge_bytelane_ram #(
    parameter int unsigned WORDS   = 1024,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [3:0]               i_we,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    (* ram_init_file = "poc/poc0.mem" *) logic [7:0] r_lane0 [WORDS];
    (* ram_init_file = "poc/poc1.mem" *) logic [7:0] r_lane1 [WORDS];
    (* ram_init_file = "poc/poc2.mem" *) logic [7:0] r_lane2 [WORDS];
    (* ram_init_file = "poc/poc3.mem" *) logic [7:0] r_lane3 [WORDS];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we[0]) r_lane0[i_addr] <= i_wdata[7:0];
            if (i_we[1]) r_lane1[i_addr] <= i_wdata[15:8];
            if (i_we[2]) r_lane2[i_addr] <= i_wdata[23:16];
            if (i_we[3]) r_lane3[i_addr] <= i_wdata[31:24];
            o_rdata <= {r_lane3[i_addr], r_lane2[i_addr], r_lane1[i_addr], r_lane0[i_addr]};
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Memory-mapped target for the core load/store port: byte-lane RAM, GPIO output bank,
// read-only debug register/PC windows and a 64-bit cycle counter with a high-word shadow.
// Ports: clk, rst_n (async active-low), bus (slave handshake), dbg_regs (32 x 32 register
//        snapshot), dbg_pc (current PC), gpio_out (channel i at [i*GPIO_WIDTH +: GPIO_WIDTH]).
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned NUM_GPIO    = 1,
    parameter int unsigned GPIO_WIDTH  = 10,
    parameter bit          RAM_INIT_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mmio_bridge_if.slave                   bus,
    input  logic [31:0][31:0]              dbg_regs,
    input  addr_t                          dbg_pc,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_out
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    state_e                         r_state;
    addr_t                          r_addr;
    data_t                          r_wdata;
    logic [3:0]                     r_wstrb;
    data_t                          r_rdata;
    logic                           r_err;
    logic                           r_sel_ram;
    logic [63:0]                    r_cyc;
    logic [31:0]                    r_shadow;
    logic [NUM_GPIO*GPIO_WIDTH-1:0] r_gpio;

    tgt_e                           w_tgt;
    logic                           w_wr;
    logic                           w_ram_en;
    data_t                          w_ram_rdata;
    logic [3:0]                     w_gpio_idx;
    data_t                          w_rd_val;
    data_t                          w_gpio_word;
    logic [NUM_GPIO*GPIO_WIDTH-1:0] w_gpio_d;

    assign w_tgt      = decode(r_addr, r_wstrb, MEM_WORDS, NUM_GPIO);
    assign w_wr       = |r_wstrb;
    assign w_ram_en   = (r_state == StAccess) && (w_tgt == TgtRam);
    assign w_gpio_idx = r_addr[5:2];

    mmio_bridge_bytelane_ram #(
        .WORDS   (MEM_WORDS),
        .INIT_EN (RAM_INIT_EN)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (r_wstrb),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Read value for non-RAM targets; RAM data comes straight from the RAM output register.
    always_comb begin
        w_rd_val = '0;
        unique case (w_tgt)
            TgtGpio: begin
                for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                    if (w_gpio_idx == 4'(i)) w_rd_val = 32'(r_gpio[i*GPIO_WIDTH +: GPIO_WIDTH]);
                end
            end
            TgtDbg:   w_rd_val = dbg_regs[r_addr[6:2]];
            TgtPc:    w_rd_val = dbg_pc;
            TgtCycLo: w_rd_val = r_cyc[31:0];
            TgtCycHi: w_rd_val = r_shadow;
            default:  w_rd_val = '0;
        endcase
        if (w_wr) w_rd_val = '0;
    end

    // GPIO merge: widen the channel to a word, patch enabled lanes, truncate back.
    always_comb begin
        w_gpio_d    = r_gpio;
        w_gpio_word = '0;
        if (r_state == StAccess && w_tgt == TgtGpio && w_wr) begin
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                if (w_gpio_idx == 4'(i)) begin
                    w_gpio_word = 32'(r_gpio[i*GPIO_WIDTH +: GPIO_WIDTH]);
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (r_wstrb[b]) w_gpio_word[b*8 +: 8] = r_wdata[b*8 +: 8];
                    end
                    w_gpio_d[i*GPIO_WIDTH +: GPIO_WIDTH] = w_gpio_word[GPIO_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_sel_ram <= 1'b0;
            r_cyc     <= '0;
            r_shadow  <= '0;
            r_gpio    <= '0;
        end else begin
            r_cyc  <= r_cyc + 64'd1;
            r_gpio <= w_gpio_d;
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_wstrb <= bus.req_wstrb;
                        r_state <= StAccess;
                    end
                end
                StAccess: begin
                    r_rdata   <= w_rd_val;
                    r_err     <= (w_tgt == TgtErr);
                    r_sel_ram <= (w_tgt == TgtRam) && !w_wr;
                    if (w_tgt == TgtCycLo) r_shadow <= r_cyc[63:32];
                    r_state   <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // req_ready is gated by rst_n so it is low for the whole reset window.
    assign bus.req_ready  = rst_n && (r_state == StIdle);
    assign bus.resp_valid = (r_state == StResp);
    assign bus.resp_rdata = r_sel_ram ? w_ram_rdata : r_rdata;
    assign bus.resp_err   = r_err;
    assign gpio_out       = r_gpio;

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;
    import mmio_bridge_pkg::*;

    localparam int unsigned MW = 64;
    localparam int unsigned NG = 2;
    localparam int unsigned GW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0][31:0] dbg_regs;
    addr_t             dbg_pc;
    logic [NG*GW-1:0]  gpio_out;

    mmio_bridge_if bus();

    mmio_bridge #(
        .MEM_WORDS   (MW),
        .NUM_GPIO    (NG),
        .GPIO_WIDTH  (GW),
        .RAM_INIT_EN (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_regs (dbg_regs),
        .dbg_pc   (dbg_pc),
        .gpio_out (gpio_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One full transaction; lat counts clock edges from request presentation to resp_valid.
    task automatic txn(input addr_t a, input data_t d, input logic [3:0] s,
                       output data_t rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("req_ready_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (lat >= 20) chk("resp_valid_timeout", 64'(lat), 64'd2);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    typedef struct {
        addr_t      addr;
        data_t      wdata;
        logic [3:0] wstrb;
        data_t      rdata;
        logic       err;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    data_t rd;
    logic  er;
    int    lat;
    data_t lo_val;

    initial begin
        for (int i = 0; i < 32; i++) dbg_regs[i] = 32'hA500_0000 | 32'(i);
        dbg_pc         = 32'h0040_0123;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.resp_ready = 1'b0;

        vecs[0]  = '{32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h0000_0040, 32'h0000_AA00, 4'h2, 32'h0, 1'b0};
        vecs[3]  = '{32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{32'h0000_0044, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vecs[5]  = '{32'h0000_0044, 32'h1122_3344, 4'h8, 32'h0, 1'b0};
        vecs[6]  = '{32'h0000_0044, 32'h0,         4'h0, 32'h11FE_F00D, 1'b0};
        vecs[7]  = '{32'h1000_0000, 32'h0000_02AB, 4'hF, 32'h0, 1'b0};
        vecs[8]  = '{32'h1000_0000, 32'h0,         4'h0, 32'h0000_02AB, 1'b0};
        vecs[9]  = '{32'h1000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0};
        vecs[10] = '{32'h1000_0004, 32'h0,         4'h0, 32'h0000_03FF, 1'b0};
        vecs[11] = '{32'h1000_0000, 32'h0,         4'h0, 32'h0000_02AB, 1'b0};
        vecs[12] = '{32'h1000_0000, 32'h0000_0155, 4'h1, 32'h0, 1'b0};
        vecs[13] = '{32'h1000_0000, 32'h0,         4'h0, 32'h0000_0255, 1'b0};
        vecs[14] = '{32'h2000_0080, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
        vecs[15] = '{32'h3000_0000, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[16] = '{32'h0000_0042, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[17] = '{32'h0000_0042, 32'h5555_5555, 4'hF, 32'h0, 1'b1};
        vecs[18] = '{32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[19] = '{32'h1000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vecs[20] = '{32'h0000_0100, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[21] = '{32'h2000_0014, 32'h0,         4'h0, 32'hA500_0005, 1'b0};
        vecs[22] = '{32'h2000_007C, 32'h0,         4'h0, 32'hA500_001F, 1'b0};
        vecs[23] = '{32'h2000_0080, 32'h0,         4'h0, 32'h0040_0123, 1'b0};
        vecs[24] = '{32'h2000_0004, 32'hFFFF_FFFF, 4'h1, 32'h0, 1'b1};
        vecs[25] = '{32'h2000_0088, 32'h0,         4'h0, 32'h0, 1'b0};

        // Reset state
        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst_gpio", 64'(gpio_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].rdata));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].err));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
        end
        chk("gpio_out_after_vecs", 64'(gpio_out), 64'({10'h3FF, 10'h255}));

        // Counter carry: LO captured at 0xFFFF_FFFE, HI read after the live carry.
        @(negedge clk);
        force dut.r_cyc = 64'h0000_0000_FFFF_FFFC;
        @(negedge clk);
        release dut.r_cyc;
        txn(CYC_LO_ADDR, 32'h0, 4'h0, lo_val, er, lat);
        chk("cyc_lo_before_carry", 64'(lo_val), 64'h0000_0000_FFFF_FFFE);
        txn(CYC_HI_ADDR, 32'h0, 4'h0, rd, er, lat);
        chk("cyc_hi_shadow_pre_carry", 64'(rd), 64'd0);
        txn(CYC_LO_ADDR, 32'h0, 4'h0, lo_val, er, lat);
        chk("cyc_lo_wrapped_small", 64'(lo_val < 32'h100), 64'd1);
        txn(CYC_HI_ADDR, 32'h0, 4'h0, rd, er, lat);
        chk("cyc_hi_after_carry", 64'(rd), 64'd1);

        // Write in ACCESS on the edge before reset is committed.
        txn(32'h0000_0080, 32'h1111_2222, 4'hF, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0080;
        bus.req_wdata = 32'h3333_4444;
        bus.req_wstrb = 4'hF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(32'h0000_0080, 32'h0, 4'h0, rd, er, lat);
        chk("rst_after_access_commit", 64'(rd), 64'h3333_4444);

        // Reset during ACCESS drops the write.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wdata = 32'h5555_6666;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(32'h0000_0080, 32'h0, 4'h0, rd, er, lat);
        chk("rst_in_access_no_write", 64'(rd), 64'h3333_4444);

        // Stall in RESP, then reset while the response is pending.
        txn(32'h1000_0004, 32'h0000_0123, 4'hF, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1000_0004;
        bus.req_wstrb = 4'h0;
        @(posedge clk);
        #1 bus.req_addr = 32'h2000_0080;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_resp_valid", c), 64'(bus.resp_valid), 64'd1);
            chk($sformatf("stall%0d_rdata", c), 64'(bus.resp_rdata), 64'h123);
            chk($sformatf("stall%0d_req_ready", c), 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_in_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_in_resp_gpio", 64'(gpio_out), 64'd0);
        chk("rst_in_resp_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(32'h1000_0004, 32'h0, 4'h0, rd, er, lat);
        chk("gpio_after_reset_read", 64'(rd), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
